dl_sdram_writer: RTL

Downstream stage of the SPI download port: consumes the byte-write strobe stream (wr/a/d plus downloading) in the core clock domain. Packs bytes into 16-bit little-endian words and buffers them in a small FIFO. Issues word writes to the SDRAM controller port over a req/ack handshake. Reports busy and the loaded image size so the core can hold its CPU in reset until the image is fully committed.

---
 rtl/dl_pkg.sv | 21 ++
 rtl/dl_wfifo.sv | 48 ++++
 rtl/dl_sdram_writer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/dl_pkg.sv
// Shared types for the download-to-SDRAM writer: write-buffer entry layout,
// byte-enable encodings and the issue FSM states.
package dl_pkg;
  localparam int ADDR_W  = 24;
  localparam int DATA_W  = 16;
  localparam int BE_W    = 2;
  localparam int ENTRY_W = ADDR_W + DATA_W + BE_W;

  localparam logic [BE_W-1:0] BE_NONE = 2'b00;
  localparam logic [BE_W-1:0] BE_LO   = 2'b01;
  localparam logic [BE_W-1:0] BE_HI   = 2'b10;
  localparam logic [BE_W-1:0] BE_FULL = 2'b11;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} issue_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } wentry_t;
endpackage

// File: rtl/dl_wfifo.sv
// Synchronous first-word-fall-through FIFO; a push on a full FIFO is ignored
// unless a pop happens in the same cycle.
module dl_wfifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 42
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             wr_en, rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/dl_sdram_writer.sv
// Packs download byte strobes into little-endian 16-bit words, buffers them
// and issues them to the SDRAM port over a req/ack handshake.
module dl_sdram_writer
  import dl_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [23:0] BASE_WADDR = 24'h000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [23:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_be,
  output logic        busy,
  output logic [24:0] rom_size,
  output logic        overflow
);
  logic act_q, rise, fall;
  assign rise = dl_active && !act_q;
  assign fall = !dl_active && act_q;

  // Pack register: valid whenever any lane is occupied
  logic [23:0] pk_addr_q, pk_addr_d;
  logic [7:0]  pk_lo_q, pk_lo_d, pk_hi_q, pk_hi_d;
  logic [1:0]  pk_be_q, pk_be_d;
  logic        pk_vld;
  logic [23:0] wadr;
  logic [1:0]  lane_be;
  logic        push;
  wentry_t     push_e, head;
  logic        fifo_full, fifo_empty, pop;

  assign pk_vld  = |pk_be_q;
  assign wadr    = dl_addr[24:1];
  assign lane_be = dl_addr[0] ? BE_HI : BE_LO;

  always_comb begin
    pk_addr_d = pk_addr_q;
    pk_lo_d   = pk_lo_q;
    pk_hi_d   = pk_hi_q;
    pk_be_d   = pk_be_q;
    push      = 1'b0;
    push_e    = '{addr: pk_addr_q, data: {pk_hi_q, pk_lo_q}, be: pk_be_q};
    if (dl_wr) begin
      // A new word or a repeated lane evicts the partial word as it stands
      if (pk_vld && (pk_addr_q != wadr || (pk_be_q & lane_be) != BE_NONE))
        push = 1'b1;
      if (!pk_vld || push) begin
        pk_addr_d = wadr;
        pk_lo_d   = 8'h00;
        pk_hi_d   = 8'h00;
        pk_be_d   = BE_NONE;
      end
      if (dl_addr[0]) pk_hi_d = dl_data;
      else            pk_lo_d = dl_data;
      pk_be_d = pk_be_d | lane_be;
      if (pk_be_d == BE_FULL) begin
        push    = 1'b1;
        push_e  = '{addr: pk_addr_d, data: {pk_hi_d, pk_lo_d}, be: BE_FULL};
        pk_be_d = BE_NONE;
      end
    end else if (fall && pk_vld) begin
      push    = 1'b1;
      pk_be_d = BE_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_q     <= 1'b0;
      pk_addr_q <= '0;
      pk_lo_q   <= '0;
      pk_hi_q   <= '0;
      pk_be_q   <= BE_NONE;
    end else begin
      act_q     <= dl_active;
      pk_addr_q <= pk_addr_d;
      pk_lo_q   <= pk_lo_d;
      pk_hi_q   <= pk_hi_d;
      pk_be_q   <= pk_be_d;
    end
  end

  logic [24:0] addr_p1, rom_base;
  assign addr_p1  = dl_addr + 25'd1;
  assign rom_base = rise ? 25'd0 : rom_size;

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_size <= '0;
      overflow <= 1'b0;
    end else begin
      rom_size <= (dl_wr && addr_p1 > rom_base) ? addr_p1 : rom_base;
      overflow <= (overflow && !rise) || (push && fifo_full && !pop);
    end
  end

  dl_wfifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_e),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Issue FSM: the head stays in the FIFO until the controller accepts it
  issue_state_t state_q, state_d;
  logic         load;

  assign mem_req = (state_q == REQ);
  assign pop     = (state_q == REQ) && mem_ack;
  assign busy    = pk_vld || !fifo_empty || mem_req;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        load    = 1'b1;
        state_d = REQ;
      end
      REQ:  if (mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_be   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        mem_addr <= head.addr + BASE_WADDR;
        mem_din  <= head.data;
        mem_be   <= head.be;
      end
    end
  end
endmodule
